// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package serial_arith_pkg;

  // Controller states; IDLE is the only state that accepts operands and
  // DONE the only one that presents a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operation mode latched at accept time.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of a counter that must reach n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// One DIGIT-wide slice of a ripple adder. Purely combinational.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] total;

  // Full DIGIT+1-bit sum; the top bit is the carry out of the slice.
  always_comb begin
    total = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    s     = total[DIGIT-1:0];
    co    = total[DIGIT];
    // The carry into the top bit is recovered from that bit's sum, which
    // avoids slicing x/y below the MSB (empty when DIGIT is 1).
    c_msb = total[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle over WIDTH-bit
// operands, with valid/ready handshakes on both sides.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  // Reject geometries the serial datapath cannot handle.
  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               mode_q, mode_d;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_co;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic                   last_dig;

  // Low digit of the working operands through the shared slice adder.
  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .ci   (carry_q),
    .s    (dig_s),
    .co   (dig_co),
    .c_msb(dig_cmsb)
  );

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // New digit enters at the MSB side so the result ends LSB-aligned; the
  // concatenation keeps this legal when DIGIT equals WIDTH.
  assign sum_cat  = {dig_s, sum_q};
  assign last_dig = (cnt_q == LAST_CNT);

  // Next-state, datapath and flag computation.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + ~borrow, so invert B and the borrow once
          // here and run the same adder for both modes.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          sum_d   = '0;
          mode_d  = sub ? MODE_SUB : MODE_ADD;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_co;
        if (last_dig) begin
          // Carry out is a borrow in subtract mode, hence the inversion.
          // Signed overflow is mode-independent because B is pre-inverted.
          cout_d  = (mode_q == MODE_SUB) ? ~dig_co : dig_co;
          ovf_d   = dig_co ^ dig_cmsb;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the operand shift registers are ordinary flops, not a memory, so
    // they are reset along with everything else and a mid-operation reset
    // leaves no stale partial result behind.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mode_q  <= MODE_ADD;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge regardless of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: an 8-bit/1-bit-digit instance and a
// 16-bit/4-bit-digit instance share one clock.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // 8-bit, DIGIT=1 instance
  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cout8, ovf8;

  // 16-bit, DIGIT=4 instance
  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cout16, ovf16;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(sub16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on either instance: accept, measure latency, check
  // result, retire it, and confirm the result persists into IDLE.
  task automatic op(input string tag, input bit w16,
                    input logic [15:0] a, input logic [15:0] b,
                    input logic s, input logic ci,
                    input logic [15:0] es, input logic ec, input logic eo);
    int cyc;
    check({tag, "_in_ready"}, w16 ? ir16 : ir8, 1);
    if (w16) begin a16 = a; b16 = b; sub16 = s; cin16 = ci; iv16 = 1'b1; end
    else     begin a8 = a[7:0]; b8 = b[7:0]; sub8 = s; cin8 = ci; iv8 = 1'b1; end
    tick();
    iv8 = 1'b0;
    iv16 = 1'b0;
    cyc = 0;
    while (!(w16 ? ov16 : ov8) && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, w16 ? 4 : 8);
    check({tag, "_sum"},  w16 ? sum16 : {8'h00, sum8}, es);
    check({tag, "_cout"}, w16 ? cout16 : cout8, ec);
    check({tag, "_ovf"},  w16 ? ovf16 : ovf8, eo);
    if (w16) or16 = 1'b1; else or8 = 1'b1;
    tick();
    or8 = 1'b0;
    or16 = 1'b0;
    check({tag, "_idle"}, w16 ? ir16 : ir8, 1);
    check({tag, "_hold"}, w16 ? sum16 : {8'h00, sum8}, es);
  endtask

  initial begin
    int  cyc;
    bit  stable_ok;
    bit  pulse_seen;

    #12 rst = 1'b0;
    tick();

    // Reset state
    check("rst_in_ready8", ir8, 1);
    check("rst_out_valid8", ov8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_ovf8", ovf8, 0);
    check("rst_in_ready16", ir16, 1);
    check("rst_sum16", sum16, 0);

    // Basic add / sub on the bit-serial instance
    op("add_5a_3c",  1'b0, 16'h005A, 16'h003C, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1);
    op("sub_10_20",  1'b0, 16'h0010, 16'h0020, 1'b1, 1'b0, 16'h00F0, 1'b1, 1'b0);
    op("sub_80_01",  1'b0, 16'h0080, 16'h0001, 1'b1, 1'b0, 16'h007F, 1'b0, 1'b1);
    op("sub_05_03b", 1'b0, 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);

    // Nibble-serial instance
    op("add16_7fff", 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op("sub16_eq_b", 1'b1, 16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Back-pressure: inputs churn during RUN and DONE, result must hold.
    a8 = 8'h40; b8 = 8'h40; sub8 = 1'b0; cin8 = 1'b0; iv8 = 1'b1;
    tick();
    cyc = 0;
    while (!ov8 && cyc < 40) begin
      iv8 = ~iv8; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; cin8 = 1'b1;
      tick();
      cyc++;
    end
    check("bp_latency", cyc, 8);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iv8 = ~iv8;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      tick();
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || sum8 !== 8'h80 || ovf8 !== 1'b1 || cout8 !== 1'b0)
        stable_ok = 1'b0;
    end
    check("bp_stable", stable_ok, 1);
    check("bp_sum", sum8, 8'h80);
    iv8 = 1'b0;
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    check("bp_release_valid", ov8, 0);
    check("bp_release_ready", ir8, 1);
    sub8 = 1'b0;
    cin8 = 1'b0;

    // Carry chain
    op("add_00_00_c", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    op("add_ff_01",   1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset mid-RUN (count==3), leaves cout=1 from above.
    a8 = 8'hFF; b8 = 8'h00; sub8 = 1'b0; cin8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (3) tick();
    check("mid_run_partial", sum8, 8'hE0);
    rst = 1'b1;
    #1;
    check("arst_out_valid", ov8, 0);
    check("arst_in_ready", ir8, 1);
    check("arst_sum", sum8, 0);
    check("arst_cout", cout8, 0);
    #8 rst = 1'b0;
    pulse_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov8) pulse_seen = 1'b1;
    end
    check("arst_no_pulse", pulse_seen, 0);
    op("post_rst_add", 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
